// File: rtl/clock_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clock_set_ctrl
// Purpose  : 1 Hz tick generation and hour/minute/second time-set sequencer
//            driving BCD load strobes, field select and blink for display.
// Revision : 1.0 - initial release
// ============================================================================
module clock_set_ctrl #(
    parameter int TICK_DIV  = 100000000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [7:0] hour_in,
    input  logic [7:0] minute_in,
    input  logic [7:0] second_in,
    output logic       tick,
    output logic       ld_h,
    output logic       ld_m,
    output logic       ld_s,
    output logic [7:0] ld_val,
    output logic [7:0] edit_val,
    output logic [1:0] sel,
    output logic       blink
);

    localparam int c_TW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
    localparam int c_BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [c_TW-1:0] c_TICK_MAX  = c_TW'(TICK_DIV - 1);
    localparam logic [c_BW-1:0] c_BLINK_MAX = c_BW'(BLINK_DIV - 1);
    localparam logic [7:0] c_HOUR_MAX = 8'h23;
    localparam logic [7:0] c_MS_MAX   = 8'h59;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_SET_H = 2'd1,
        S_SET_M = 2'd2,
        S_SET_S = 2'd3
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [c_TW-1:0] r_presc, w_presc_nxt;
    logic [c_BW-1:0] r_bcnt,  w_bcnt_nxt;
    logic [7:0]      r_edit,  w_edit_nxt;
    logic [7:0]      r_ld_val, w_ld_val_nxt;
    logic            r_tick, w_tick_nxt;
    logic            r_ld_h, w_ld_h_nxt;
    logic            r_ld_m, w_ld_m_nxt;
    logic            r_ld_s, w_ld_s_nxt;
    logic            r_blink, w_blink_nxt;

    logic r_mode_s1, r_mode_s2, r_mode_prev;
    logic r_inc_s1,  r_inc_s2,  r_inc_prev;
    logic w_mode_edge, w_inc_edge;

    // Out-of-range values (>= max) wrap to zero, so bad captures self-correct
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        logic [7:0] res;
        if (v >= max)
            res = 8'h00;
        else if (v[3:0] >= 4'd9)
            res = {v[7:4] + 4'd1, 4'd0};
        else
            res = {v[7:4], v[3:0] + 4'd1};
        return res;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mode_s1   <= 1'b0;
            r_mode_s2   <= 1'b0;
            r_mode_prev <= 1'b0;
            r_inc_s1    <= 1'b0;
            r_inc_s2    <= 1'b0;
            r_inc_prev  <= 1'b0;
        end else begin
            r_mode_s1   <= btn_mode;
            r_mode_s2   <= r_mode_s1;
            r_mode_prev <= r_mode_s2;
            r_inc_s1    <= btn_inc;
            r_inc_s2    <= r_inc_s1;
            r_inc_prev  <= r_inc_s2;
        end
    end

    assign w_mode_edge = r_mode_s2 & ~r_mode_prev;
    assign w_inc_edge  = r_inc_s2  & ~r_inc_prev;

    always_comb begin
        w_state_nxt  = r_state;
        w_presc_nxt  = r_presc;
        w_edit_nxt   = r_edit;
        w_ld_val_nxt = r_ld_val;
        w_tick_nxt   = 1'b0;
        w_ld_h_nxt   = 1'b0;
        w_ld_m_nxt   = 1'b0;
        w_ld_s_nxt   = 1'b0;
        w_bcnt_nxt   = r_bcnt;
        w_blink_nxt  = r_blink;

        // Mode always takes priority over inc, so the strobe carries the
        // unincremented edit value.
        case (r_state)
            S_RUN: begin
                if (w_mode_edge) begin
                    w_state_nxt = S_SET_H;
                    w_edit_nxt  = hour_in;
                end else begin
                    w_tick_nxt  = (r_presc == c_TICK_MAX);
                    w_presc_nxt = (r_presc == c_TICK_MAX) ? '0 : r_presc + 1'b1;
                end
            end
            S_SET_H: begin
                if (w_mode_edge) begin
                    w_ld_h_nxt   = 1'b1;
                    w_ld_val_nxt = r_edit;
                    w_state_nxt  = S_SET_M;
                    w_edit_nxt   = minute_in;
                end else if (w_inc_edge) begin
                    w_edit_nxt = bcd_inc(r_edit, c_HOUR_MAX);
                end
            end
            S_SET_M: begin
                if (w_mode_edge) begin
                    w_ld_m_nxt   = 1'b1;
                    w_ld_val_nxt = r_edit;
                    w_state_nxt  = S_SET_S;
                    w_edit_nxt   = second_in;
                end else if (w_inc_edge) begin
                    w_edit_nxt = bcd_inc(r_edit, c_MS_MAX);
                end
            end
            default: begin
                if (w_mode_edge) begin
                    w_ld_s_nxt   = 1'b1;
                    w_ld_val_nxt = r_edit;
                    w_state_nxt  = S_RUN;
                    w_presc_nxt  = '0;
                end else if (w_inc_edge) begin
                    w_edit_nxt = bcd_inc(r_edit, c_MS_MAX);
                end
            end
        endcase

        // Restart the blink phase on every field change so the new field is lit
        if (w_state_nxt != r_state) begin
            w_bcnt_nxt  = '0;
            w_blink_nxt = (w_state_nxt != S_RUN);
        end else if (r_state == S_RUN) begin
            w_bcnt_nxt  = '0;
            w_blink_nxt = 1'b0;
        end else if (r_bcnt == c_BLINK_MAX) begin
            w_bcnt_nxt  = '0;
            w_blink_nxt = ~r_blink;
        end else begin
            w_bcnt_nxt = r_bcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_RUN;
            r_presc  <= '0;
            r_bcnt   <= '0;
            r_edit   <= 8'h00;
            r_ld_val <= 8'h00;
            r_tick   <= 1'b0;
            r_ld_h   <= 1'b0;
            r_ld_m   <= 1'b0;
            r_ld_s   <= 1'b0;
            r_blink  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_presc  <= w_presc_nxt;
            r_bcnt   <= w_bcnt_nxt;
            r_edit   <= w_edit_nxt;
            r_ld_val <= w_ld_val_nxt;
            r_tick   <= w_tick_nxt;
            r_ld_h   <= w_ld_h_nxt;
            r_ld_m   <= w_ld_m_nxt;
            r_ld_s   <= w_ld_s_nxt;
            r_blink  <= w_blink_nxt;
        end
    end

    assign tick     = r_tick;
    assign ld_h     = r_ld_h;
    assign ld_m     = r_ld_m;
    assign ld_s     = r_ld_s;
    assign ld_val   = r_ld_val;
    assign edit_val = (r_state == S_RUN) ? 8'h00 : r_edit;
    assign sel      = r_state;
    assign blink    = r_blink;

endmodule
`default_nettype wire
